// File: rtl/multi_cycle_control.sv
// multi_cycle_control
// Multi-cycle control sequencer for the RV32I core. Steps the datapath through
// FETCH, DECODE, EXECUTE, MEM and WB according to the decoded instruction-type
// code, handles EBREAK halt/resume and counts retired instructions.
//
// Optional build macro: TRAP_EN
//   defined   - TRAP state, illegal-mode trap and MEM timeout counter are built
//   undefined - illegal modes retire as nop, MEM waits forever, trap tied 0
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   mode[3:0]           instruction type code (12..15 behave as illegal)
//   imem_valid          fetched word valid (FETCH only)
//   dmem_ready          data access complete (MEM only)
//   branch_taken        branch comparator result (EXECUTE only)
//   resume              leave HALT
//   imem_req, ir_load   fetch request / instruction register load
//   pc_load, pc_src     PC update strobe and source select
//   alu_src_a/b         ALU operand selects
//   wb_sel, rd_we       writeback mux select / register write enable
//   dmem_rd, dmem_wr    data memory strobes
//   halted, trap        registered status flags
//   state[2:0]          current state (debug)
//   instret[CNT_W-1:0]  retired-instruction counter (wraps)
module multi_cycle_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       mode,
    input  logic             imem_valid,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    input  logic             resume,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       wb_sel,
    output logic             rd_we,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             halted,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        M_NOP     = 4'd0,
        M_R       = 4'd1,
        M_I       = 4'd2,
        M_LOAD    = 4'd3,
        M_STORE   = 4'd4,
        M_BRANCH  = 4'd5,
        M_JAL     = 4'd6,
        M_LUI     = 4'd7,
        M_AUIPC   = 4'd8,
        M_ILLEGAL = 4'd9,
        M_JALR    = 4'd10,
        M_EBREAK  = 4'd11
    } mode_t;

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
        $error("multi_cycle_control: MEM_TIMEOUT and CNT_W must be at least 1");
    end

    state_t           r_state;
    state_t           w_next;
    mode_t            w_mode;
    logic             r_halted;
    logic [CNT_W-1:0] r_instret;

    // Unassigned codes fold onto the illegal type.
    assign w_mode = (mode > 4'd11) ? M_ILLEGAL : mode_t'(mode);

`ifdef TRAP_EN
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TMO_W-1:0] r_mem_cnt;
    logic             w_mem_timeout;
    logic             r_trap;

    // Counts MEM cycles already spent; held at zero outside MEM so every
    // MEM entry starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_cnt <= '0;
        end else if (r_state != S_MEM) begin
            r_mem_cnt <= '0;
        end else begin
            r_mem_cnt <= r_mem_cnt + TMO_W'(1);
        end
    end

    assign w_mem_timeout = (r_mem_cnt == TMO_W'(MEM_TIMEOUT - 1)) && !dmem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= (w_next == S_TRAP);
        end
    end

    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        wb_sel    = 2'd0;
        rd_we     = 1'b0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;

        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_load = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_mode)
                    M_EBREAK:  w_next = S_HALT;
`ifdef TRAP_EN
                    M_ILLEGAL: w_next = S_TRAP;
`endif
                    default:   w_next = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                case (w_mode)
                    M_R: w_next = S_WB;
                    M_I: begin
                        alu_src_b = 1'b1;
                        w_next    = S_WB;
                    end
                    M_LOAD, M_STORE: begin
                        alu_src_b = 1'b1;
                        w_next    = S_MEM;
                    end
                    M_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        w_next    = S_WB;
                    end
                    M_LUI, M_JAL, M_JALR: w_next = S_WB;
                    M_BRANCH: begin
                        pc_load = 1'b1;
                        pc_src  = {1'b0, branch_taken};
                        w_next  = S_FETCH;
                    end
                    // nop, and illegal when it is not trapped
                    default: begin
                        pc_load = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_rd = (w_mode == M_LOAD);
                dmem_wr = (w_mode == M_STORE);
                if (dmem_ready) begin
                    if (w_mode == M_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        pc_load = 1'b1;
                        w_next  = S_FETCH;
                    end
                end
`ifdef TRAP_EN
                if (w_mem_timeout) begin
                    w_next = S_TRAP;
                end
`endif
            end
            S_WB: begin
                rd_we   = 1'b1;
                pc_load = 1'b1;
                case (w_mode)
                    M_LOAD:        wb_sel = 2'd1;
                    M_JAL, M_JALR: wb_sel = 2'd2;
                    M_LUI:         wb_sel = 2'd3;
                    default:       wb_sel = 2'd0;
                endcase
                case (w_mode)
                    M_JAL:   pc_src = 2'd1;
                    M_JALR:  pc_src = 2'd2;
                    default: pc_src = 2'd0;
                endcase
                w_next = S_FETCH;
            end
            S_HALT: begin
                if (resume) begin
                    pc_load = 1'b1;
                    w_next  = S_FETCH;
                end
            end
`ifdef TRAP_EN
            S_TRAP: w_next = S_TRAP;
`endif
            default: w_next = S_FETCH;
        endcase

        // State already reads FETCH during reset; keep every strobe low too.
        if (reset) begin
            imem_req  = 1'b0;
            ir_load   = 1'b0;
            pc_load   = 1'b0;
            pc_src    = 2'd0;
            alu_src_a = 1'b0;
            alu_src_b = 1'b0;
            wb_sel    = 2'd0;
            rd_we     = 1'b0;
            dmem_rd   = 1'b0;
            dmem_wr   = 1'b0;
        end
    end

    // Every pc_load marks a retiring instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_halted  <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == S_HALT);
            if (pc_load) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign state   = r_state;
    assign halted  = r_halted;
    assign instret = r_instret;

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;
    localparam int CW  = 4;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    mode = 4'd0;
    logic          imem_valid = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          branch_taken = 1'b0;
    logic          resume = 1'b0;
    logic          imem_req, ir_load, pc_load, alu_src_a, alu_src_b, rd_we;
    logic          dmem_rd, dmem_wr, halted, trap;
    logic [1:0]    pc_src, wb_sel;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    multi_cycle_control #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .mode(mode), .imem_valid(imem_valid),
        .dmem_ready(dmem_ready), .branch_taken(branch_taken), .resume(resume),
        .imem_req(imem_req), .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel), .rd_we(rd_we),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .halted(halted), .trap(trap),
        .state(state), .instret(instret)
    );

    // One expected cycle: inputs to apply and the full output picture.
    typedef struct packed {
        logic        iv;
        logic        dr;
        logic        bt;
        logic        rs;
        logic [16:0] exp;
    } cyc_t;

    cyc_t        q_cyc[$];
    logic [16:0] q_obs[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_instret = 0;

    function automatic logic [16:0] mk(input int st, input bit req, input bit irl, input bit pcl,
                                       input int psrc, input bit a, input bit b, input int wb,
                                       input bit we, input bit rd, input bit wr, input bit hlt,
                                       input bit trp);
        return {3'(st), req, irl, pcl, 2'(psrc), a, b, 2'(wb), we, rd, wr, hlt, trp};
    endfunction

    function automatic logic [16:0] obs();
        return {state, imem_req, ir_load, pc_load, pc_src, alu_src_a, alu_src_b,
                wb_sel, rd_we, dmem_rd, dmem_wr, halted, trap};
    endfunction

    function automatic bit rnd();
        return ($urandom & 1) != 0;
    endfunction

    // Reference model: lists the cycles one instruction should take, phase by
    // phase, from the type code and the handshake delays.
    task automatic model_instr(input int m, input int fw, input int mw, input bit bt,
                               input int hw, output bit retires);
        int em;
        bit a, b, rd, wr;
        int wb, ps;
        em = (m > 11) ? 9 : m;
        retires = 1'b1;
        for (int k = 0; k < fw; k++)
            q_cyc.push_back('{1'b0, rnd(), rnd(), rnd(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        q_cyc.push_back('{1'b1, rnd(), rnd(), rnd(), mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        q_cyc.push_back('{rnd(), rnd(), rnd(), rnd(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
`ifdef TRAP_EN
        if (em == 9) begin
            for (int k = 0; k < 4; k++)
                q_cyc.push_back('{rnd(), rnd(), rnd(), rnd(), mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
            retires = 1'b0;
            return;
        end
`endif
        if (em == 11) begin
            for (int k = 0; k < hw; k++)
                q_cyc.push_back('{rnd(), rnd(), rnd(), 1'b0, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
            q_cyc.push_back('{rnd(), rnd(), rnd(), 1'b1, mk(5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
            return;
        end
        if (em == 0 || em == 9) begin
            q_cyc.push_back('{rnd(), rnd(), rnd(), rnd(), mk(2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
            return;
        end
        if (em == 5) begin
            q_cyc.push_back('{rnd(), rnd(), bt, rnd(), mk(2, 0, 0, 1, bt ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0)});
            return;
        end
        a = (em == 8);
        b = (em == 2 || em == 3 || em == 4 || em == 8);
        q_cyc.push_back('{rnd(), rnd(), rnd(), rnd(), mk(2, 0, 0, 0, 0, a, b, 0, 0, 0, 0, 0, 0)});
        if (em == 3 || em == 4) begin
            rd = (em == 3);
            wr = (em == 4);
`ifdef TRAP_EN
            if (mw >= TMO) begin
                for (int k = 0; k < TMO; k++)
                    q_cyc.push_back('{rnd(), 1'b0, rnd(), rnd(), mk(3, 0, 0, 0, 0, 0, 0, 0, 0, rd, wr, 0, 0)});
                for (int k = 0; k < 4; k++)
                    q_cyc.push_back('{rnd(), rnd(), rnd(), rnd(), mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
                retires = 1'b0;
                return;
            end
`endif
            for (int k = 0; k < mw; k++)
                q_cyc.push_back('{rnd(), 1'b0, rnd(), rnd(), mk(3, 0, 0, 0, 0, 0, 0, 0, 0, rd, wr, 0, 0)});
            if (wr) begin
                q_cyc.push_back('{rnd(), 1'b1, rnd(), rnd(), mk(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)});
                return;
            end
            q_cyc.push_back('{rnd(), 1'b1, rnd(), rnd(), mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)});
        end
        wb = (em == 3) ? 1 : (em == 6 || em == 10) ? 2 : (em == 7) ? 3 : 0;
        ps = (em == 6) ? 1 : (em == 10) ? 2 : 0;
        q_cyc.push_back('{rnd(), rnd(), rnd(), rnd(), mk(4, 0, 0, 1, ps, 0, 0, wb, 1, 0, 0, 0, 0)});
    endtask

    // Applies the first n modelled cycles and records the outputs of each.
    task automatic run_model(input int n);
        q_obs.delete();
        for (int i = 0; i < n; i++) begin
            imem_valid   = q_cyc[i].iv;
            dmem_ready   = q_cyc[i].dr;
            branch_taken = q_cyc[i].bt;
            resume       = q_cyc[i].rs;
            @(negedge clk);
            q_obs.push_back(obs());
            @(posedge clk);
            #1;
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        resume     = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_instret = 0;
    endtask

    task automatic test_reset();
        imem_valid = 1'b1;
        dmem_ready = 1'b1;
        resume     = 1'b1;
        #1 reset = 1'b1;
        #2;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        checks++;
        if (instret !== '0) begin
            errors++;
            $display("FAIL reset_instret: got %0d want 0", instret);
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        resume     = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL first_fetch: got %h want %h", obs(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        exp_instret = 0;
    endtask

    task automatic test_rtype();
        bit r;
        mode = 4'd1;
        q_cyc.delete();
        model_instr(1, 0, 0, 1'b0, 0, r);
        checks++;
        if (instret !== CW'(exp_instret)) begin
            errors++;
            $display("FAIL rtype_instret_before: got %0d want %0d", instret, exp_instret);
        end
        run_model(q_cyc.size());
        foreach (q_obs[i]) begin
            checks++;
            if (q_obs[i] !== q_cyc[i].exp) begin
                errors++;
                $display("FAIL rtype cyc%0d: got %h want %h", i, q_obs[i], q_cyc[i].exp);
            end
        end
        exp_instret++;
        checks++;
        if (instret !== CW'(exp_instret)) begin
            errors++;
            $display("FAIL rtype_instret_after: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_load_stall();
        bit r;
        mode = 4'd3;
        q_cyc.delete();
        model_instr(3, 0, 3, 1'b0, 0, r);
        checks++;
        if (q_cyc.size() != 8) begin
            errors++;
            $display("FAIL load_len: got %0d want 8", q_cyc.size());
        end
        run_model(q_cyc.size());
        foreach (q_obs[i]) begin
            checks++;
            if (q_obs[i] !== q_cyc[i].exp) begin
                errors++;
                $display("FAIL load_stall cyc%0d: got %h want %h", i, q_obs[i], q_cyc[i].exp);
            end
        end
        exp_instret++;
        checks++;
        if (instret !== CW'(exp_instret)) begin
            errors++;
            $display("FAIL load_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_branch_jalr();
        bit r;
        int modes[2] = '{5, 10};
        foreach (modes[k]) begin
            mode = 4'(modes[k]);
            q_cyc.delete();
            model_instr(modes[k], 0, 0, 1'b1, 0, r);
            run_model(q_cyc.size());
            foreach (q_obs[i]) begin
                checks++;
                if (q_obs[i] !== q_cyc[i].exp) begin
                    errors++;
                    $display("FAIL mode%0d cyc%0d: got %h want %h", modes[k], i, q_obs[i], q_cyc[i].exp);
                end
            end
            exp_instret++;
            checks++;
            if (instret !== CW'(exp_instret)) begin
                errors++;
                $display("FAIL mode%0d_instret: got %0d want %0d", modes[k], instret, exp_instret);
            end
        end
    endtask

    task automatic test_ebreak();
        bit r;
        mode = 4'd11;
        q_cyc.delete();
        model_instr(11, 1, 0, 1'b0, 5, r);
        run_model(q_cyc.size());
        foreach (q_obs[i]) begin
            checks++;
            if (q_obs[i] !== q_cyc[i].exp) begin
                errors++;
                $display("FAIL ebreak cyc%0d: got %h want %h", i, q_obs[i], q_cyc[i].exp);
            end
        end
        exp_instret++;
        checks++;
        if (instret !== CW'(exp_instret) || state !== 3'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_exit: got instret=%0d state=%0d halted=%b want %0d 0 0",
                     instret, state, halted, exp_instret);
        end
    endtask

    task automatic test_illegal();
        bit r;
        int modes[2] = '{9, 13};
        foreach (modes[k]) begin
            mode = 4'(modes[k]);
            q_cyc.delete();
            model_instr(modes[k], 0, 0, 1'b0, 0, r);
            run_model(q_cyc.size());
            foreach (q_obs[i]) begin
                checks++;
                if (q_obs[i] !== q_cyc[i].exp) begin
                    errors++;
                    $display("FAIL illegal%0d cyc%0d: got %h want %h", modes[k], i, q_obs[i], q_cyc[i].exp);
                end
            end
            if (r) exp_instret++;
            checks++;
            if (instret !== CW'(exp_instret)) begin
                errors++;
                $display("FAIL illegal%0d_instret: got %0d want %0d", modes[k], instret, exp_instret);
            end
            if (!r) begin
                apply_reset();
                checks++;
                if (state !== 3'd0 || trap !== 1'b0 || instret !== '0) begin
                    errors++;
                    $display("FAIL trap_clear: got state=%0d trap=%b instret=%0d want 0 0 0",
                             state, trap, instret);
                end
            end
        end
    endtask

`ifdef TRAP_EN
    task automatic test_store_timeout();
        bit r;
        mode = 4'd4;
        q_cyc.delete();
        model_instr(4, 0, TMO, 1'b0, 0, r);
        run_model(q_cyc.size());
        foreach (q_obs[i]) begin
            checks++;
            if (q_obs[i] !== q_cyc[i].exp) begin
                errors++;
                $display("FAIL store_timeout cyc%0d: got %h want %h", i, q_obs[i], q_cyc[i].exp);
            end
        end
        apply_reset();
        checks++;
        if (trap !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL timeout_clear: got trap=%b state=%0d want 0 0", trap, state);
        end
    endtask
`endif

    task automatic test_random();
        bit r;
        int m;
        for (int n = 0; n < 40; n++) begin
            m = int'($urandom_range(0, 15));
`ifdef TRAP_EN
            if (m == 9 || m > 11) m = 1;
`endif
            mode = 4'(m);
            q_cyc.delete();
            model_instr(m, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), rnd(),
                        int'($urandom_range(0, 3)), r);
            run_model(q_cyc.size());
            foreach (q_obs[i]) begin
                checks++;
                if (q_obs[i] !== q_cyc[i].exp) begin
                    errors++;
                    $display("FAIL random%0d mode%0d cyc%0d: got %h want %h", n, m, i, q_obs[i], q_cyc[i].exp);
                end
            end
            if (r) exp_instret++;
            checks++;
            if (instret !== CW'(exp_instret)) begin
                errors++;
                $display("FAIL random%0d_instret: got %0d want %0d", n, instret, exp_instret % (1 << CW));
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        bit r;
        mode = 4'd3;
        q_cyc.delete();
        model_instr(3, 0, 10, 1'b0, 0, r);
        run_model(5);
        foreach (q_obs[i]) begin
            checks++;
            if (q_obs[i] !== q_cyc[i].exp) begin
                errors++;
                $display("FAIL mid_mem cyc%0d: got %h want %h", i, q_obs[i], q_cyc[i].exp);
            end
        end
        dmem_ready = 1'b0;
        #1;
        checks++;
        if (dmem_rd !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_rd_before: got %b want 1", dmem_rd);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL mid_mem_reset: got %h want %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_instret = 0;
        checks++;
        if (obs() !== mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0) || instret !== '0) begin
            errors++;
            $display("FAIL mid_mem_release: got %h instret=%0d want %h 0", obs(), instret,
                     mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_stall();
        test_branch_jalr();
        test_ebreak();
        test_illegal();
`ifdef TRAP_EN
        test_store_timeout();
`endif
        test_random();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
